// File: rtl/dram_store_buf.sv
// Store buffer between byte-enable generation and the data RAM write port.
// It lane-shifts each store and queues it in order, and flags loads that hit a pending word.
module dram_store_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            st_valid_i,
  output logic            st_ready_o,
  input  logic [XLEN-1:0] st_addr_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [3:0]      st_byte_en_i,
  input  logic            ld_chk_en_i,
  input  logic [XLEN-1:0] ld_addr_i,
  output logic            ld_hazard_o,
  output logic            dram_wr_en_o,
  input  logic            dram_wr_gnt_i,
  output logic [XLEN-1:0] dram_wr_addr_o,
  output logic [XLEN-1:0] dram_wr_data_o,
  output logic [3:0]      dram_wr_byte_en_o,
  output logic            misalign_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [XLEN-3:0] entry_addr [DEPTH];
  logic [XLEN-1:0] entry_data [DEPTH];
  logic [3:0]      entry_be   [DEPTH];

  logic [DEPTH-1:0] valid_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             misalign_reg;

  logic [1:0]       sh;
  logic [XLEN-1:0]  data_sh;
  logic [3:0]       be_sh;
  logic             take;
  logic             misaligned;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] hit;

  assign sh      = st_addr_i[1:0];
  assign data_sh = st_data_i << {sh, 3'b000};
  assign be_sh   = st_byte_en_i << sh;

  assign empty_o    = (count_reg == '0);
  assign full_o     = (count_reg == FULL_CNT);
  assign st_ready_o = ~full_o;

  // Misaligned and all-zero-enable stores are consumed but never queued.
  assign take       = st_valid_i && st_ready_o;
  assign misaligned = ((st_byte_en_i == 4'b0011) && st_addr_i[0]) ||
                      ((st_byte_en_i == 4'b1111) && (st_addr_i[1:0] != 2'b00));
  assign push       = take && (st_byte_en_i != 4'b0000) && !misaligned;
  assign pop        = dram_wr_en_o && dram_wr_gnt_i;

  assign dram_wr_en_o      = ~empty_o;
  assign dram_wr_addr_o    = empty_o ? '0 : {entry_addr[rd_ptr_reg], 2'b00};
  assign dram_wr_data_o    = empty_o ? '0 : entry_data[rd_ptr_reg];
  assign dram_wr_byte_en_o = empty_o ? 4'b0000 : entry_be[rd_ptr_reg];
  assign misalign_o        = misalign_reg;

  // Word-granular match; the entry being popped this cycle is still valid here.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = valid_reg[gi] && (entry_addr[gi] == ld_addr_i[XLEN-1:2]);
    end
  endgenerate

  assign ld_hazard_o = ld_chk_en_i && (|hit);

  always_ff @(posedge clk_i) begin
    if (push) begin
      entry_addr[wr_ptr_reg] <= st_addr_i[XLEN-1:2];
      entry_data[wr_ptr_reg] <= data_sh;
      entry_be[wr_ptr_reg]   <= be_sh;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= take && misaligned;
      if (push) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg            <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_store_buf.sv
// Directed bench for dram_store_buf: lane shift, misalign drop, full stall,
// back-to-back flow, load hazard and mid-operation reset.
module tb_dram_store_buf;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        st_valid_i = 1'b0;
  logic        st_ready_o;
  logic [31:0] st_addr_i = '0;
  logic [31:0] st_data_i = '0;
  logic [3:0]  st_byte_en_i = '0;
  logic        ld_chk_en_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic        ld_hazard_o;
  logic        dram_wr_en_o;
  logic        dram_wr_gnt_i = 1'b0;
  logic [31:0] dram_wr_addr_o;
  logic [31:0] dram_wr_data_o;
  logic [3:0]  dram_wr_byte_en_o;
  logic        misalign_o;
  logic        empty_o;
  logic        full_o;

  int errors = 0;
  int checks = 0;

  dram_store_buf #(.XLEN(32), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_byte_en_i(st_byte_en_i),
    .ld_chk_en_i(ld_chk_en_i), .ld_addr_i(ld_addr_i), .ld_hazard_o(ld_hazard_o),
    .dram_wr_en_o(dram_wr_en_o), .dram_wr_gnt_i(dram_wr_gnt_i),
    .dram_wr_addr_o(dram_wr_addr_o), .dram_wr_data_o(dram_wr_data_o),
    .dram_wr_byte_en_o(dram_wr_byte_en_o),
    .misalign_o(misalign_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    st_valid_i   = v;
    st_addr_i    = a;
    st_data_i    = d;
    st_byte_en_i = be;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dram_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", dram_wr_en_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    checks++; if (st_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", st_ready_o); end
    step();
    rst_n_i = 1'b1;
    #1;
    checks++; if ({full_o, misalign_o, ld_hazard_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {full_o, misalign_o, ld_hazard_o}); end
    checks++; if ({dram_wr_addr_o, dram_wr_data_o, dram_wr_byte_en_o} !== 68'h0) begin errors++; $display("FAIL reset_head: got %h want 0", {dram_wr_addr_o, dram_wr_data_o, dram_wr_byte_en_o}); end
    $display("test_reset done");
  endtask

  task automatic test_byte_store();
    set_store(1'b1, 32'h0000_1003, 32'h0000_00A5, 4'b0001);
    #1;
    checks++; if (dram_wr_en_o !== 1'b0) begin errors++; $display("FAIL byte_no_bypass: got %b want 0", dram_wr_en_o); end
    step();
    set_store(1'b0, '0, '0, '0);
    checks++; if (dram_wr_en_o !== 1'b1) begin errors++; $display("FAIL byte_wr_en: got %b want 1", dram_wr_en_o); end
    checks++; if (dram_wr_addr_o !== 32'h0000_1000) begin errors++; $display("FAIL byte_addr: got %h want 00001000", dram_wr_addr_o); end
    checks++; if (dram_wr_data_o !== 32'hA500_0000) begin errors++; $display("FAIL byte_data: got %h want a5000000", dram_wr_data_o); end
    checks++; if (dram_wr_byte_en_o !== 4'b1000) begin errors++; $display("FAIL byte_be: got %b want 1000", dram_wr_byte_en_o); end
    dram_wr_gnt_i = 1'b1;
    step();
    dram_wr_gnt_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL byte_empty: got %b want 1", empty_o); end
    checks++; if (dram_wr_data_o !== 32'h0) begin errors++; $display("FAIL byte_data_zero: got %h want 0", dram_wr_data_o); end
    $display("test_byte_store done");
  endtask

  task automatic test_half_and_misalign();
    set_store(1'b1, 32'h0000_2002, 32'h0000_BEEF, 4'b0011);
    step();
    set_store(1'b0, '0, '0, '0);
    checks++; if (dram_wr_data_o !== 32'hBEEF_0000) begin errors++; $display("FAIL half_data: got %h want beef0000", dram_wr_data_o); end
    checks++; if (dram_wr_byte_en_o !== 4'b1100) begin errors++; $display("FAIL half_be: got %b want 1100", dram_wr_byte_en_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL half_no_misalign: got %b want 0", misalign_o); end
    dram_wr_gnt_i = 1'b1;
    step();
    dram_wr_gnt_i = 1'b0;
    // Misaligned half then misaligned word: each gives a one-cycle pulse.
    set_store(1'b1, 32'h0000_2001, 32'h0000_BEEF, 4'b0011);
    step();
    set_store(1'b0, '0, '0, '0);
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_half_pulse: got %b want 1", misalign_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL mis_half_empty: got %b want 1", empty_o); end
    step();
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_half_fall: got %b want 0", misalign_o); end
    set_store(1'b1, 32'h0000_2006, 32'h1234_5678, 4'b1111);
    step();
    set_store(1'b1, 32'h0000_2008, 32'h1234_5678, 4'b0000);
    checks++; if ({misalign_o, empty_o} !== 2'b11) begin errors++; $display("FAIL mis_word: got %b want 11", {misalign_o, empty_o}); end
    step();
    set_store(1'b0, '0, '0, '0);
    checks++; if ({misalign_o, empty_o} !== 2'b01) begin errors++; $display("FAIL zero_be_dropped: got %b want 01", {misalign_o, empty_o}); end
    $display("test_half_and_misalign done");
  endtask

  task automatic test_full_and_wrap();
    logic [31:0] exp_d;
    dram_wr_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_store(1'b1, 32'h0000_4000 + 32'(4*k), 32'hD000_0000 + 32'(k), 4'b1111);
      step();
    end
    checks++; if ({full_o, st_ready_o} !== 2'b10) begin errors++; $display("FAIL full_flags: got %b want 10", {full_o, st_ready_o}); end
    set_store(1'b1, 32'h0000_4010, 32'hD000_0004, 4'b1111);
    step();
    checks++; if (dram_wr_data_o !== 32'hD000_0000) begin errors++; $display("FAIL full_stall_head: got %h want d0000000", dram_wr_data_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", full_o); end
    dram_wr_gnt_i = 1'b1;
    step();
    checks++; if ({full_o, st_ready_o} !== 2'b01) begin errors++; $display("FAIL full_after_pop: got %b want 01", {full_o, st_ready_o}); end
    checks++; if (dram_wr_data_o !== 32'hD000_0001) begin errors++; $display("FAIL wrap_d1: got %h want d0000001", dram_wr_data_o); end
    step();
    set_store(1'b0, '0, '0, '0);
    for (int k = 2; k <= 4; k++) begin
      exp_d = 32'hD000_0000 + 32'(k);
      checks++; if (dram_wr_data_o !== exp_d) begin errors++; $display("FAIL wrap_order: got %h want %h", dram_wr_data_o, exp_d); end
      step();
    end
    dram_wr_gnt_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty_o); end
    $display("test_full_and_wrap done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    logic [31:0] exp_a;
    dram_wr_gnt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_a = 32'h0000_5000 + 32'(4*i);
      exp_d = 32'h0000_0100 + 32'(i);
      set_store(1'b1, exp_a, exp_d, 4'b1111);
      step();
      checks++; if ({dram_wr_en_o, dram_wr_addr_o, dram_wr_data_o} !== {1'b1, exp_a, exp_d}) begin
        errors++; $display("FAIL b2b_head[%0d]: got %b %h %h want 1 %h %h", i, dram_wr_en_o, dram_wr_addr_o, dram_wr_data_o, exp_a, exp_d);
      end
      checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL b2b_full[%0d]: got %b want 0", i, full_o); end
    end
    set_store(1'b0, '0, '0, '0);
    step();
    dram_wr_gnt_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty_o); end
    $display("test_back_to_back done");
  endtask

  task automatic test_load_hazard();
    set_store(1'b1, 32'h0000_3004, 32'hCAFE_F00D, 4'b1111);
    step();
    set_store(1'b0, '0, '0, '0);
    ld_chk_en_i = 1'b1; ld_addr_i = 32'h0000_3007; #1;
    checks++; if (ld_hazard_o !== 1'b1) begin errors++; $display("FAIL haz_same_word: got %b want 1", ld_hazard_o); end
    ld_addr_i = 32'h0000_3008; #1;
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL haz_next_word: got %b want 0", ld_hazard_o); end
    ld_chk_en_i = 1'b0; ld_addr_i = 32'h0000_3004; #1;
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL haz_disabled: got %b want 0", ld_hazard_o); end
    ld_chk_en_i = 1'b1; dram_wr_gnt_i = 1'b1; #1;
    checks++; if (ld_hazard_o !== 1'b1) begin errors++; $display("FAIL haz_grant_cycle: got %b want 1", ld_hazard_o); end
    step();
    dram_wr_gnt_i = 1'b0;
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL haz_after_pop: got %b want 0", ld_hazard_o); end
    set_store(1'b1, 32'h0000_6000, 32'h0000_0001, 4'b1111);
    ld_addr_i = 32'h0000_6002; #1;
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL haz_same_cycle_store: got %b want 0", ld_hazard_o); end
    step();
    set_store(1'b0, '0, '0, '0);
    checks++; if (ld_hazard_o !== 1'b1) begin errors++; $display("FAIL haz_after_push: got %b want 1", ld_hazard_o); end
    ld_chk_en_i = 1'b0;
    dram_wr_gnt_i = 1'b1;
    step();
    dram_wr_gnt_i = 1'b0;
    $display("test_load_hazard done");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      set_store(1'b1, 32'h0000_7000 + 32'(4*k), 32'hEE00_0000 + 32'(k), 4'b1111);
      step();
    end
    set_store(1'b0, '0, '0, '0);
    checks++; if (dram_wr_en_o !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b want 1", dram_wr_en_o); end
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if ({dram_wr_en_o, empty_o, full_o} !== 3'b010) begin errors++; $display("FAIL rmid_async: got %b want 010", {dram_wr_en_o, empty_o, full_o}); end
    checks++; if (dram_wr_data_o !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h want 0", dram_wr_data_o); end
    step();
    rst_n_i = 1'b1;
    dram_wr_gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if ({dram_wr_en_o, empty_o} !== 2'b01) begin errors++; $display("FAIL rmid_no_stale[%0d]: got %b want 01", k, {dram_wr_en_o, empty_o}); end
    end
    dram_wr_gnt_i = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_and_misalign();
    test_full_and_wrap();
    test_back_to_back();
    test_load_hazard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
